// File: rtl/mips_pkg.sv
// Shared types and widths for the EX-stage operand path.
package mips_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int IMM_WIDTH      = 16;

  // ALU operation codes understood by the downstream ALU.
  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOR = 4'b1100,
    ALU_LUI = 4'b1000,
    ALU_DIV = 4'b1010,
    ALU_MOD = 4'b1011
  } alu_op_e;

  // One buffered operation: resolved operands plus control.
  // alu_control is kept as raw bits so any code passes through unchanged.
  typedef struct packed {
    logic [DATA_WIDTH-1:0]     a;
    logic [DATA_WIDTH-1:0]     b;
    logic [3:0]                alu_control;
    logic [REG_ADDR_WIDTH-1:0] dest;
  } ex_op_t;

endpackage

// File: rtl/forward_mux.sv
// Resolves one source operand against the EX/MEM and MEM/WB write ports.
// EX/MEM is younger and wins; register 0 is never forwarded.
module forward_mux #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0]     rf_data_i,
  input  logic                      exmem_wr_en_i,
  input  logic [REG_ADDR_WIDTH-1:0] exmem_rd_i,
  input  logic [DATA_WIDTH-1:0]     exmem_data_i,
  input  logic                      memwb_wr_en_i,
  input  logic [REG_ADDR_WIDTH-1:0] memwb_rd_i,
  input  logic [DATA_WIDTH-1:0]     memwb_data_i,
  output logic [DATA_WIDTH-1:0]     val_o
);

  // Priority select: EX/MEM, then MEM/WB, then register file.
  always_comb begin
    val_o = rf_data_i;
    if (addr_i != '0) begin
      if (exmem_wr_en_i && (exmem_rd_i == addr_i)) begin
        val_o = exmem_data_i;
      end else if (memwb_wr_en_i && (memwb_rd_i == addr_i)) begin
        val_o = memwb_data_i;
      end
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// EX-stage front end: forwards rs/rt, extends the immediate, and holds the
// resolved operation in a 2-entry skid buffer (main drives the ALU).
module alu_operand_stage #(
  parameter int DATA_WIDTH     = mips_pkg::DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = mips_pkg::REG_ADDR_WIDTH,
  parameter int IMM_WIDTH      = mips_pkg::IMM_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [REG_ADDR_WIDTH-1:0] rs_addr,
  input  logic [REG_ADDR_WIDTH-1:0] rt_addr,
  input  logic [DATA_WIDTH-1:0]     rs_data,
  input  logic [DATA_WIDTH-1:0]     rt_data,
  input  logic [IMM_WIDTH-1:0]      imm,
  input  logic                      alu_src,
  input  logic                      sign_ext,
  input  logic [3:0]                alu_control_in,
  input  logic [REG_ADDR_WIDTH-1:0] dest_in,
  input  logic                      exmem_wr_en,
  input  logic [REG_ADDR_WIDTH-1:0] exmem_rd,
  input  logic [DATA_WIDTH-1:0]     exmem_data,
  input  logic                      memwb_wr_en,
  input  logic [REG_ADDR_WIDTH-1:0] memwb_rd,
  input  logic [DATA_WIDTH-1:0]     memwb_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     alu_a,
  output logic [DATA_WIDTH-1:0]     alu_b,
  output logic [3:0]                alu_control,
  output logic [REG_ADDR_WIDTH-1:0] dest_out
);

  import mips_pkg::*;

  logic [DATA_WIDTH-1:0] fwd_a;
  logic [DATA_WIDTH-1:0] fwd_b;
  logic [DATA_WIDTH-1:0] imm_ext;
  ex_op_t                new_op;

  ex_op_t main_q, main_d;
  ex_op_t skid_q, skid_d;
  logic   main_vld_q, main_vld_d;
  logic   skid_vld_q, skid_vld_d;

  logic accept;
  logic drain;

  forward_mux #(
    .DATA_WIDTH    (DATA_WIDTH),
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
  ) u_fwd_rs (
    .addr_i       (rs_addr),
    .rf_data_i    (rs_data),
    .exmem_wr_en_i(exmem_wr_en),
    .exmem_rd_i   (exmem_rd),
    .exmem_data_i (exmem_data),
    .memwb_wr_en_i(memwb_wr_en),
    .memwb_rd_i   (memwb_rd),
    .memwb_data_i (memwb_data),
    .val_o        (fwd_a)
  );

  forward_mux #(
    .DATA_WIDTH    (DATA_WIDTH),
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
  ) u_fwd_rt (
    .addr_i       (rt_addr),
    .rf_data_i    (rt_data),
    .exmem_wr_en_i(exmem_wr_en),
    .exmem_rd_i   (exmem_rd),
    .exmem_data_i (exmem_data),
    .memwb_wr_en_i(memwb_wr_en),
    .memwb_rd_i   (memwb_rd),
    .memwb_data_i (memwb_data),
    .val_o        (fwd_b)
  );

  // in_ready comes straight from the skid valid flop, so it is registered.
  assign in_ready    = !skid_vld_q;
  assign accept      = in_valid && in_ready;
  assign drain       = main_vld_q && out_ready;

  assign out_valid   = main_vld_q;
  assign alu_a       = main_q.a;
  assign alu_b       = main_q.b;
  assign alu_control = main_q.alu_control;
  assign dest_out    = main_q.dest;

  // Build the incoming operation: immediate extension and B-operand select.
  always_comb begin
    imm_ext            = {{(DATA_WIDTH-IMM_WIDTH){sign_ext & imm[IMM_WIDTH-1]}}, imm};
    new_op             = '0;
    new_op.a           = fwd_a;
    new_op.b           = alu_src ? imm_ext : fwd_b;
    new_op.alu_control = alu_control_in;
    new_op.dest        = dest_in;
  end

  // Skid-buffer next state; flush clears both entries and zeroes the outputs.
  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    if (flush) begin
      main_d     = '0;
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (drain) begin
      if (skid_vld_q) begin
        // in_ready is low here, so no new operation competes with the skid.
        main_d     = skid_q;
        skid_vld_d = 1'b0;
      end else if (accept) begin
        main_d = new_op;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (!main_vld_q) begin
      if (accept) begin
        main_d     = new_op;
        main_vld_d = 1'b1;
      end
    end else if (accept) begin
      // Main is stalled: park the new operation in the skid entry.
      skid_d     = new_op;
      skid_vld_d = 1'b1;
    end
  end

  // Buffer registers; reset has priority over everything else.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: forwarding, immediates, skid buffer.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready;
  logic [4:0]  rs_addr, rt_addr, dest_in, exmem_rd, memwb_rd, dest_out;
  logic [31:0] rs_data, rt_data, exmem_data, memwb_data, alu_a, alu_b;
  logic [15:0] imm;
  logic        alu_src, sign_ext, exmem_wr_en, memwb_wr_en, out_valid, out_ready;
  logic [3:0]  alu_control_in, alu_control;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_operand_stage dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .rs_addr       (rs_addr),
    .rt_addr       (rt_addr),
    .rs_data       (rs_data),
    .rt_data       (rt_data),
    .imm           (imm),
    .alu_src       (alu_src),
    .sign_ext      (sign_ext),
    .alu_control_in(alu_control_in),
    .dest_in       (dest_in),
    .exmem_wr_en   (exmem_wr_en),
    .exmem_rd      (exmem_rd),
    .exmem_data    (exmem_data),
    .memwb_wr_en   (memwb_wr_en),
    .memwb_rd      (memwb_rd),
    .memwb_data    (memwb_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_control   (alu_control),
    .dest_out      (dest_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [4:0] rsa, input logic [4:0] rta,
                          input logic [31:0] rsd, input logic [31:0] rtd,
                          input logic [15:0] im, input logic src, input logic sx,
                          input logic [3:0] ctl, input logic [4:0] dst);
    in_valid       = 1'b1;
    rs_addr        = rsa;
    rt_addr        = rta;
    rs_data        = rsd;
    rt_data        = rtd;
    imm            = im;
    alu_src        = src;
    sign_ext       = sx;
    alu_control_in = ctl;
    dest_in        = dst;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    rs_addr = '0; rt_addr = '0; rs_data = '0; rt_data = '0; imm = '0;
    alu_src = 1'b0; sign_ext = 1'b0; alu_control_in = '0; dest_in = '0;
    exmem_wr_en = 1'b0; exmem_rd = '0; exmem_data = '0;
    memwb_wr_en = 1'b0; memwb_rd = '0; memwb_data = '0;
    step(); step();
    reset = 1'b0;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    check("rst_alu_control", {28'd0, alu_control}, 32'd0);
    check("rst_dest", {27'd0, dest_out}, 32'd0);

    // Basic accept, no forwarding.
    out_ready = 1'b1;
    drive_op(5'd1, 5'd2, 32'd5, 32'd7, 16'd0, 1'b0, 1'b0, 4'b0010, 5'd9);
    step();
    in_valid = 1'b0;
    check("basic_valid", {31'd0, out_valid}, 32'd1);
    check("basic_a", alu_a, 32'd5);
    check("basic_b", alu_b, 32'd7);
    check("basic_ctl", {28'd0, alu_control}, 32'h2);
    check("basic_dest", {27'd0, dest_out}, 32'd9);

    // Forwarding priority.
    exmem_wr_en = 1'b1; exmem_rd = 5'd3; exmem_data = 32'hAA;
    memwb_wr_en = 1'b1; memwb_rd = 5'd3; memwb_data = 32'hBB;
    drive_op(5'd3, 5'd3, 32'h11, 32'h22, 16'd0, 1'b0, 1'b0, 4'b0110, 5'd4);
    step();
    check("fwd_exmem_a", alu_a, 32'hAA);
    check("fwd_exmem_b", alu_b, 32'hAA);
    exmem_wr_en = 1'b0;
    step();
    check("fwd_memwb_a", alu_a, 32'hBB);
    exmem_wr_en = 1'b1; exmem_rd = 5'd0; memwb_rd = 5'd0;
    drive_op(5'd0, 5'd2, 32'h11, 32'h22, 16'd0, 1'b0, 1'b0, 4'b0001, 5'd4);
    step();
    check("fwd_r0_a", alu_a, 32'h11);
    check("fwd_nomatch_b", alu_b, 32'h22);

    // Immediate extension; rt forwarding hit must not leak into B.
    exmem_wr_en = 1'b1; exmem_rd = 5'd3; exmem_data = 32'hAA;
    drive_op(5'd1, 5'd3, 32'd1, 32'd2, 16'hFFF0, 1'b1, 1'b1, 4'b1000, 5'd6);
    step();
    check("imm_sext", alu_b, 32'hFFFFFFF0);
    sign_ext = 1'b0;
    step();
    check("imm_zext", alu_b, 32'h0000FFF0);
    check("imm_ctl", {28'd0, alu_control}, 32'h8);
    exmem_wr_en = 1'b0; memwb_wr_en = 1'b0;
    in_valid = 1'b0;
    step();
    check("drain_empty", {31'd0, out_valid}, 32'd0);

    // Backpressure: op1 held, op2 skidded, op3 refused until drain.
    out_ready = 1'b0;
    drive_op(5'd1, 5'd2, 32'd1, 32'd0, 16'd0, 1'b0, 1'b0, 4'd1, 5'd1);
    step();
    check("bp_op1_a", alu_a, 32'd1);
    check("bp_rdy_after_op1", {31'd0, in_ready}, 32'd1);
    drive_op(5'd1, 5'd2, 32'd2, 32'd0, 16'd0, 1'b0, 1'b0, 4'd2, 5'd2);
    step();
    check("bp_hold_op1", alu_a, 32'd1);
    check("bp_rdy_low", {31'd0, in_ready}, 32'd0);
    drive_op(5'd1, 5'd2, 32'd3, 32'd0, 16'd0, 1'b0, 1'b0, 4'd3, 5'd3);
    step(); step();
    check("bp_still_op1", alu_a, 32'd1);
    check("bp_still_dest1", {27'd0, dest_out}, 32'd1);
    check("bp_rdy_still_low", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    step();
    check("bp_op2_a", alu_a, 32'd2);
    check("bp_op2_valid", {31'd0, out_valid}, 32'd1);
    check("bp_rdy_rise", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    check("bp_op3_a", alu_a, 32'd3);
    check("bp_op3_ctl", {28'd0, alu_control}, 32'd3);
    step();
    check("bp_no_dup", {31'd0, out_valid}, 32'd0);

    // Streaming: one op per cycle, no bubbles.
    for (int i = 0; i < 5; i++) begin
      drive_op(5'd1, 5'd2, 32'd100 + i, 32'd0, 16'd0, 1'b0, 1'b0, 4'd2, 5'd7);
      step();
      check("stream_a", alu_a, 32'd100 + i);
      check("stream_valid", {31'd0, out_valid}, 32'd1);
      check("stream_rdy", {31'd0, in_ready}, 32'd1);
    end
    in_valid = 1'b0;
    step();

    // Flush with skid full and an op presented.
    out_ready = 1'b0;
    drive_op(5'd1, 5'd2, 32'h21, 32'h5, 16'd0, 1'b0, 1'b0, 4'd7, 5'd2);
    step();
    drive_op(5'd1, 5'd2, 32'h22, 32'h5, 16'd0, 1'b0, 1'b0, 4'd7, 5'd2);
    step();
    check("fl_skid_full", {31'd0, in_ready}, 32'd0);
    flush = 1'b1;
    drive_op(5'd1, 5'd2, 32'h23, 32'h5, 16'd0, 1'b0, 1'b0, 4'd7, 5'd2);
    step();
    check("fl_valid", {31'd0, out_valid}, 32'd0);
    check("fl_rdy", {31'd0, in_ready}, 32'd1);
    check("fl_a_zero", alu_a, 32'd0);
    check("fl_b_zero", alu_b, 32'd0);
    check("fl_ctl_zero", {28'd0, alu_control}, 32'd0);
    step();
    check("fl_drop_concurrent", {31'd0, out_valid}, 32'd0);
    flush = 1'b0;
    in_valid = 1'b0;
    step();
    check("fl_stay_empty", {31'd0, out_valid}, 32'd0);

    // Reset and flush together over a full main entry.
    drive_op(5'd1, 5'd2, 32'h31, 32'h32, 16'd0, 1'b0, 1'b0, 4'd11, 5'd5);
    step();
    check("rf_loaded", alu_a, 32'h31);
    reset = 1'b1; flush = 1'b1;
    step();
    check("rf_valid", {31'd0, out_valid}, 32'd0);
    check("rf_rdy", {31'd0, in_ready}, 32'd1);
    check("rf_a", alu_a, 32'd0);
    check("rf_b", alu_b, 32'd0);
    check("rf_dest", {27'd0, dest_out}, 32'd0);
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
